// File: rtl/alu_issue.sv
// Registered RV32I decode-and-issue stage feeding the single-cycle alu over valid/ready.
// Define ALU_ISSUE_SKID_EN to add a skid entry and a registered in_ready.
module alu_issue #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs1_val,
  input  logic [31:0]      rs2_val,
  input  logic [31:0]      pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       aluc,
  output logic [31:0]      a,
  output logic [31:0]      b,
  output logic             is_branch,
  output logic             illegal,
  output logic             err_sticky,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SLL  = 5'b00101;
  localparam logic [4:0] ALU_SLT  = 5'b00110;
  localparam logic [4:0] ALU_SLTU = 5'b00111;
  localparam logic [4:0] ALU_SRL  = 5'b01000;
  localparam logic [4:0] ALU_SRA  = 5'b01001;
  localparam logic [4:0] ALU_JALR = 5'b01010;
  localparam logic [4:0] ALU_BEQ  = 5'b01011;
  localparam logic [4:0] ALU_BNE  = 5'b01100;
  localparam logic [4:0] ALU_BLT  = 5'b01101;
  localparam logic [4:0] ALU_BGE  = 5'b01110;
  localparam logic [4:0] ALU_BLTU = 5'b01111;
  localparam logic [4:0] ALU_BGEU = 5'b10000;

  typedef struct packed {
    logic [4:0]  aluc;
    logic [31:0] a;
    logic [31:0] b;
    logic        isBranch;
    logic        illegal;
  } bundle_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] immI;
  logic [31:0] immS;
  logic [31:0] immU;
  logic        unusedRd;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign immI     = {{20{instr[31]}}, instr[31:20]};
  assign immS     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign immU     = {instr[31:12], 12'b0};
  assign unusedRd = ^instr[11:7];

  logic        decIllegal;
  logic [4:0]  decAluc;
  logic [31:0] decA;
  logic [31:0] decB;
  bundle_t     dec;

  // The alu shifts b by a[4:0], so shift decodes swap rs1 into b and put shamt in a.
  always_comb begin
    decIllegal = 1'b0;
    decAluc    = ALU_ADD;
    decA       = rs1_val;
    decB       = rs2_val;
    case (opcode)
      OP_REG: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000: decAluc = ALU_ADD;
            3'b001: begin decAluc = ALU_SLL; decA = {27'b0, rs2_val[4:0]}; decB = rs1_val; end
            3'b010: decAluc = ALU_SLT;
            3'b011: decAluc = ALU_SLTU;
            3'b100: decAluc = ALU_XOR;
            3'b101: begin decAluc = ALU_SRL; decA = {27'b0, rs2_val[4:0]}; decB = rs1_val; end
            3'b110: decAluc = ALU_OR;
            default: decAluc = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          decAluc = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          decAluc = ALU_SRA;
          decA    = {27'b0, rs2_val[4:0]};
          decB    = rs1_val;
        end else begin
          decIllegal = 1'b1;
        end
      end
      OP_IMM: begin
        decB = immI;
        case (funct3)
          3'b000: decAluc = ALU_ADD;
          3'b010: decAluc = ALU_SLT;
          3'b011: decAluc = ALU_SLTU;
          3'b100: decAluc = ALU_XOR;
          3'b110: decAluc = ALU_OR;
          3'b111: decAluc = ALU_AND;
          3'b001: begin
            decAluc    = ALU_SLL;
            decA       = {27'b0, instr[24:20]};
            decB       = rs1_val;
            decIllegal = (funct7 != F7_BASE);
          end
          default: begin
            decAluc    = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            decA       = {27'b0, instr[24:20]};
            decB       = rs1_val;
            decIllegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
          end
        endcase
      end
      OP_LUI:   begin decA = 32'd0; decB = immU; end
      OP_AUIPC: begin decA = pc;    decB = immU; end
      OP_LOAD:  decB = immI;
      OP_STORE: decB = immS;
      OP_JAL:   begin decA = pc;    decB = 32'd4; end
      OP_JALR:  begin decAluc = ALU_JALR; decB = immI; end
      OP_BRANCH: begin
        case (funct3)
          3'b000: decAluc = ALU_BEQ;
          3'b001: decAluc = ALU_BNE;
          3'b100: decAluc = ALU_BLT;
          3'b101: decAluc = ALU_BGE;
          3'b110: decAluc = ALU_BLTU;
          3'b111: decAluc = ALU_BGEU;
          default: decIllegal = 1'b1;
        endcase
      end
      default: decIllegal = 1'b1;
    endcase

    dec         = '0;
    dec.illegal = decIllegal;
    if (!decIllegal) begin
      dec.aluc     = decAluc;
      dec.a        = decA;
      dec.b        = decB;
      dec.isBranch = (decAluc >= ALU_BEQ) && (decAluc <= ALU_BGEU);
    end
  end

  logic accept;
  logic countUp;
  assign accept  = in_valid & in_ready;
  assign countUp = accept & dec.illegal;

  logic [CNT_W-1:0] illegalCnt_q, illegalCnt_d;
  logic             sticky_q, sticky_d;

  // Illegal accounting happens at accept time, independent of when the bundle issues.
  always_comb begin
    illegalCnt_d = illegalCnt_q;
    sticky_d     = sticky_q;
    if (countUp) begin
      sticky_d = 1'b1;
      if (illegalCnt_q != {CNT_W{1'b1}}) illegalCnt_d = illegalCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      illegalCnt_q <= '0;
      sticky_q     <= 1'b0;
    end else begin
      illegalCnt_q <= illegalCnt_d;
      sticky_q     <= sticky_d;
    end
  end

  bundle_t out_q, out_d;
  logic    outValid_q, outValid_d;

`ifdef ALU_ISSUE_SKID_EN
  bundle_t skid_q, skid_d;
  logic    skidValid_q, skidValid_d;
  logic    inReady_q;

  // Skid entry drains into the output register first so issue order matches accept order.
  always_comb begin
    out_d       = out_q;
    outValid_d  = outValid_q;
    skid_d      = skid_q;
    skidValid_d = skidValid_q;
    if (!outValid_q || out_ready) begin
      if (skidValid_q) begin
        out_d       = skid_q;
        outValid_d  = 1'b1;
        skidValid_d = accept;
        if (accept) skid_d = dec;
      end else if (accept) begin
        out_d      = dec;
        outValid_d = 1'b1;
      end else begin
        outValid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d      = dec;
      skidValid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_q      <= '0;
      skidValid_q <= 1'b0;
      inReady_q   <= 1'b1;
    end else begin
      skid_q      <= skid_d;
      skidValid_q <= skidValid_d;
      inReady_q   <= ~skidValid_d;
    end
  end

  assign in_ready = inReady_q;
`else
  always_comb begin
    out_d      = out_q;
    outValid_d = outValid_q;
    if (accept) begin
      out_d      = dec;
      outValid_d = 1'b1;
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  assign in_ready = ~outValid_q | out_ready;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      outValid_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      outValid_q <= outValid_d;
    end
  end

  assign out_valid   = outValid_q;
  assign aluc        = out_q.aluc;
  assign a           = out_q.a;
  assign b           = out_q.b;
  assign is_branch   = out_q.isBranch;
  assign illegal     = out_q.illegal;
  assign err_sticky  = sticky_q;
  assign illegal_cnt = illegalCnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed decode/handshake scenarios plus a randomized
// scoreboard driven by a mnemonic-level reference model. Honours ALU_ISSUE_SKID_EN.
module tb_alu_issue;

  localparam int CNT_W = 4;
  localparam int CNT_CAP = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      instr = '0;
  logic [31:0]      rs1_val = '0;
  logic [31:0]      rs2_val = '0;
  logic [31:0]      pc = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [4:0]       aluc;
  logic [31:0]      a;
  logic [31:0]      b;
  logic             is_branch;
  logic             illegal;
  logic             err_sticky;
  logic [CNT_W-1:0] illegal_cnt;

  always #5 clk = ~clk;

  alu_issue #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .pc(pc), .out_valid(out_valid), .out_ready(out_ready),
    .aluc(aluc), .a(a), .b(b), .is_branch(is_branch), .illegal(illegal),
    .err_sticky(err_sticky), .illegal_cnt(illegal_cnt)
  );

  typedef struct packed {
    logic [4:0]  aluc;
    logic [31:0] a;
    logic [31:0] b;
    logic        isBranch;
    logic        illegal;
  } bundle_t;

  int      checkCount = 0;
  int      passCount = 0;
  int      aluCodeOf[string];
  bundle_t expQ[$];
  int      modelCnt = 0;
  logic    modelSticky = 1'b0;
  logic    prevStall = 1'b0;
  bundle_t prevBundle;
  bundle_t obsB;
  bundle_t expB;
  logic    expIr;

  // Name the instruction first, then derive the alu code and operands from its format.
  function automatic string mnem(input logic [31:0] ins);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = ins[31:25];
    f3 = ins[14:12];
    case (ins[6:0])
      7'h33: case ({f7, f3})
        10'h000: return "add";  10'h100: return "sub";  10'h001: return "sll";
        10'h002: return "slt";  10'h003: return "sltu"; 10'h004: return "xor";
        10'h005: return "srl";  10'h105: return "sra";  10'h006: return "or";
        10'h007: return "and";  default: return "bad";
      endcase
      7'h13: case (f3)
        3'd0: return "addi"; 3'd2: return "slti"; 3'd3: return "sltiu";
        3'd4: return "xori"; 3'd6: return "ori";  3'd7: return "andi";
        3'd1: return (f7 == 7'h00) ? "slli" : "bad";
        default: return (f7 == 7'h00) ? "srli" : (f7 == 7'h20) ? "srai" : "bad";
      endcase
      7'h37: return "lui";
      7'h17: return "auipc";
      7'h03: return "load";
      7'h23: return "store";
      7'h6F: return "jal";
      7'h67: return "jalr";
      7'h63: case (f3)
        3'd0: return "beq";  3'd1: return "bne";  3'd4: return "blt";
        3'd5: return "bge";  3'd6: return "bltu"; 3'd7: return "bgeu";
        default: return "bad";
      endcase
      default: return "bad";
    endcase
  endfunction

  function automatic bundle_t refModel(input logic [31:0] ins, r1, r2, p);
    bundle_t e;
    string   m;
    int      code;
    logic [31:0] iImm;
    e = '0;
    m = mnem(ins);
    if (m == "bad") begin
      e.illegal = 1'b1;
      return e;
    end
    code = aluCodeOf[m];
    iImm = 32'($signed(ins) >>> 20);
    e.aluc = 5'(code);
    e.isBranch = (code >= 11) && (code <= 16);
    if (m == "sll" || m == "srl" || m == "sra") begin
      e.a = r2 % 32; e.b = r1;
    end else if (m == "slli" || m == "srli" || m == "srai") begin
      e.a = (ins >> 20) % 32; e.b = r1;
    end else if (m == "lui") begin
      e.a = 32'd0; e.b = ins & 32'hFFFF_F000;
    end else if (m == "auipc") begin
      e.a = p; e.b = ins & 32'hFFFF_F000;
    end else if (m == "jal") begin
      e.a = p; e.b = 32'd4;
    end else if (m == "store") begin
      e.a = r1; e.b = (iImm & ~32'h1F) | ((ins >> 7) % 32);
    end else if (m == "addi" || m == "slti" || m == "sltiu" || m == "xori" || m == "ori" ||
                 m == "andi" || m == "load" || m == "jalr") begin
      e.a = r1; e.b = iImm;
    end else begin
      e.a = r1; e.b = r2;
    end
    return e;
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] r;
    int          pick;
    logic [6:0]  ops [9];
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h6F, 7'h67, 7'h63};
    r = $urandom;
    pick = $urandom_range(0, 9);
    if (pick < 9) r[6:0] = ops[pick];
    pick = $urandom_range(0, 9);
    if (pick < 5) r[31:25] = 7'h00;
    else if (pick < 8) r[31:25] = 7'h20;
    return r;
  endfunction

  // Scoreboard: at each falling edge, judge the handshakes that the next rising edge will perform.
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
      modelCnt = 0;
      modelSticky = 1'b0;
      prevStall = 1'b0;
    end else begin
      obsB = {aluc, a, b, is_branch, illegal};
`ifdef ALU_ISSUE_SKID_EN
      expIr = (expQ.size() < 2);
`else
      expIr = (expQ.size() == 0) || out_ready;
`endif
      checkCount++;
      if (out_valid !== (expQ.size() != 0)) $display("[TB] FAIL sb.out_valid got %b want %b", out_valid, expQ.size() != 0);
      else passCount++;
      checkCount++;
      if (in_ready !== expIr) $display("[TB] FAIL sb.in_ready got %b want %b", in_ready, expIr);
      else passCount++;
      checkCount++;
      if (illegal_cnt !== CNT_W'(modelCnt) || err_sticky !== modelSticky)
        $display("[TB] FAIL sb.count got cnt=%0d sticky=%b want cnt=%0d sticky=%b", illegal_cnt, err_sticky, modelCnt, modelSticky);
      else passCount++;
      if (prevStall) begin
        checkCount++;
        if (obsB !== prevBundle) $display("[TB] FAIL sb.hold got %h want %h", obsB, prevBundle);
        else passCount++;
      end
      if (out_valid && out_ready && expQ.size() > 0) begin
        expB = expQ.pop_front();
        checkCount++;
        if (obsB !== expB) $display("[TB] FAIL sb.bundle got %h want %h", obsB, expB);
        else passCount++;
      end
      prevStall = out_valid && !out_ready;
      prevBundle = obsB;
      if (in_valid && in_ready) begin
        expB = refModel(instr, rs1_val, rs2_val, pc);
        expQ.push_back(expB);
        if (expB.illegal) begin
          modelSticky = 1'b1;
          if (modelCnt < CNT_CAP) modelCnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, r1, r2, p);
    in_valid = 1'b1; instr = ins; rs1_val = r1; rs2_val = r2; pc = p;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    checkCount++;
    if ({out_valid, aluc, a, b, is_branch, illegal, err_sticky, illegal_cnt} !== '0)
      $display("[TB] FAIL reset.state got %h want 0", {out_valid, aluc, a, b, is_branch, illegal, err_sticky, illegal_cnt});
    else passCount++;
    rst = 1'b0;
    #1;
    checkCount++;
    if (in_ready !== 1'b1) $display("[TB] FAIL reset.in_ready got %b want 1", in_ready);
    else passCount++;
  endtask

  task automatic test_decode();
    out_ready = 1'b1;
    drive(32'h003100B3, 32'd5, 32'd7, 32'h0);
    checkCount++;
    if ({out_valid, aluc, a, b, is_branch, illegal} !== {1'b1, 5'd0, 32'd5, 32'd7, 1'b0, 1'b0})
      $display("[TB] FAIL dec.add got %h", {out_valid, aluc, a, b, is_branch, illegal});
    else passCount++;
    drive(32'h4041D093, 32'h8000_0000, 32'h55, 32'h0);
    checkCount++;
    if ({out_valid, aluc, a, b, is_branch, illegal} !== {1'b1, 5'd9, 32'd4, 32'h8000_0000, 1'b0, 1'b0})
      $display("[TB] FAIL dec.srai got %h", {out_valid, aluc, a, b, is_branch, illegal});
    else passCount++;
    drive(32'h0020E463, 32'd1, 32'd2, 32'h0);
    checkCount++;
    if ({out_valid, aluc, a, b, is_branch, illegal} !== {1'b1, 5'd15, 32'd1, 32'd2, 1'b1, 1'b0})
      $display("[TB] FAIL dec.bltu got %h", {out_valid, aluc, a, b, is_branch, illegal});
    else passCount++;
    drive(32'h004080E7, 32'h101, 32'h0, 32'h0);
    checkCount++;
    if ({out_valid, aluc, a, b, is_branch, illegal} !== {1'b1, 5'd10, 32'h101, 32'd4, 1'b0, 1'b0})
      $display("[TB] FAIL dec.jalr got %h", {out_valid, aluc, a, b, is_branch, illegal});
    else passCount++;
    drive(32'h123450B7, 32'hDEAD, 32'hBEEF, 32'h40);
    checkCount++;
    if ({out_valid, aluc, a, b, is_branch, illegal} !== {1'b1, 5'd0, 32'd0, 32'h1234_5000, 1'b0, 1'b0})
      $display("[TB] FAIL dec.lui got %h", {out_valid, aluc, a, b, is_branch, illegal});
    else passCount++;
    drive(32'h00001097, 32'h0, 32'h0, 32'h1000);
    checkCount++;
    if ({aluc, a, b} !== {5'd0, 32'h1000, 32'h1000}) $display("[TB] FAIL dec.auipc got %h", {aluc, a, b});
    else passCount++;
    drive(32'hFE20AE23, 32'h200, 32'h9, 32'h0);
    checkCount++;
    if ({aluc, a, b} !== {5'd0, 32'h200, 32'hFFFF_FFFC}) $display("[TB] FAIL dec.sw got %h", {aluc, a, b});
    else passCount++;
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    in_valid = 1'b1; instr = 32'hFFFF_FFFF; rs1_val = 32'h1234; rs2_val = 32'h5678;
    tick();
    checkCount++;
    if ({out_valid, illegal, aluc, a, b, is_branch} !== {1'b1, 1'b1, 5'd0, 32'd0, 32'd0, 1'b0})
      $display("[TB] FAIL ill.first got %h", {out_valid, illegal, aluc, a, b, is_branch});
    else passCount++;
    tick();
    in_valid = 1'b0;
    checkCount++;
    if ({out_valid, illegal, aluc, a, b, is_branch} !== {1'b1, 1'b1, 5'd0, 32'd0, 32'd0, 1'b0})
      $display("[TB] FAIL ill.second got %h", {out_valid, illegal, aluc, a, b, is_branch});
    else passCount++;
    checkCount++;
    if ({err_sticky, illegal_cnt} !== {1'b1, 4'd2}) $display("[TB] FAIL ill.count got %b/%0d want 1/2", err_sticky, illegal_cnt);
    else passCount++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkCount++;
    if ({out_valid, aluc, a, b, is_branch, illegal, err_sticky, illegal_cnt} !== '0)
      $display("[TB] FAIL ill.reset got %h want 0", {out_valid, aluc, a, b, is_branch, illegal, err_sticky, illegal_cnt});
    else passCount++;
    drive(32'h02011093, 32'h77, 32'h0, 32'h0);
    checkCount++;
    if ({out_valid, illegal, aluc, a, b} !== {1'b1, 1'b1, 5'd0, 32'd0, 32'd0})
      $display("[TB] FAIL ill.slli25 got %h", {out_valid, illegal, aluc, a, b});
    else passCount++;
    drive(32'h40002033, 32'h3, 32'h4, 32'h0);
    checkCount++;
    if ({illegal, aluc, a, b, illegal_cnt} !== {1'b1, 5'd0, 32'd0, 32'd0, 4'd2})
      $display("[TB] FAIL ill.subf3 got %h", {illegal, aluc, a, b, illegal_cnt});
    else passCount++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1; in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h003100B3; rs1_val = 32'd5; rs2_val = 32'd7;
    tick();
    instr = 32'h004080E7; rs1_val = 32'h101;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkCount++;
      if ({out_valid, aluc, a, b} !== {1'b1, 5'd0, 32'd5, 32'd7}) $display("[TB] FAIL bp.hold%0d got %h", k, {out_valid, aluc, a, b});
      else passCount++;
      checkCount++;
`ifdef ALU_ISSUE_SKID_EN
      if (in_ready !== (k == 0)) $display("[TB] FAIL bp.in_ready%0d got %b want %b", k, in_ready, k == 0);
`else
      if (in_ready !== 1'b0) $display("[TB] FAIL bp.in_ready%0d got %b want 0", k, in_ready);
`endif
      else passCount++;
      tick();
`ifdef ALU_ISSUE_SKID_EN
      if (k == 0) instr = 32'h123450B7;
`endif
    end
    out_ready = 1'b1;
`ifdef ALU_ISSUE_SKID_EN
    tick();
    checkCount++;
    if ({out_valid, aluc, a, b, in_ready} !== {1'b1, 5'd10, 32'h101, 32'd4, 1'b1})
      $display("[TB] FAIL bp.skidB got %h", {out_valid, aluc, a, b, in_ready});
    else passCount++;
    tick();
    in_valid = 1'b0;
    checkCount++;
    if ({out_valid, aluc, a, b} !== {1'b1, 5'd0, 32'd0, 32'h1234_5000}) $display("[TB] FAIL bp.skidC got %h", {out_valid, aluc, a, b});
    else passCount++;
`else
    #1;
    checkCount++;
    if (in_ready !== 1'b1) $display("[TB] FAIL bp.release got %b want 1", in_ready);
    else passCount++;
    tick();
    in_valid = 1'b0;
    checkCount++;
    if ({out_valid, aluc, a, b} !== {1'b1, 5'd10, 32'h101, 32'd4}) $display("[TB] FAIL bp.nextB got %h", {out_valid, aluc, a, b});
    else passCount++;
`endif
    tick();
    checkCount++;
    if (out_valid !== 1'b0) $display("[TB] FAIL bp.empty got %b want 0", out_valid);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      in_valid = 1'b1; instr = randInstr(); rs1_val = $urandom; rs2_val = $urandom; pc = $urandom;
      tick();
      checkCount++;
      if ({in_ready, out_valid} !== 2'b11) $display("[TB] FAIL b2b.flow%0d got %b want 11", i, {in_ready, out_valid});
      else passCount++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      instr = randInstr(); rs1_val = $urandom; rs2_val = $urandom; pc = $urandom;
      tick();
      if (out_valid) begin
        checkCount++;
        if (is_branch !== (!illegal && aluc >= 5'd11 && aluc <= 5'd16) || (illegal && {aluc, a, b} !== '0))
          $display("[TB] FAIL rnd.shape got ill=%b aluc=%0d br=%b a=%h b=%h", illegal, aluc, is_branch, a, b);
        else passCount++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; instr = 32'hFFFF_FFFF;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checkCount++;
      if (illegal_cnt !== CNT_W'((i < CNT_CAP) ? i : CNT_CAP) || err_sticky !== 1'b1)
        $display("[TB] FAIL sat.cnt%0d got %0d/%b want %0d/1", i, illegal_cnt, err_sticky, (i < CNT_CAP) ? i : CNT_CAP);
      else passCount++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midstall();
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h003100B3;
    tick();
    in_valid = 1'b0;
    tick();
    checkCount++;
    if (out_valid !== 1'b1) $display("[TB] FAIL mid.stalled got %b want 1", out_valid);
    else passCount++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkCount++;
    if ({out_valid, illegal_cnt, err_sticky, in_ready} !== {1'b0, 4'd0, 1'b0, 1'b1})
      $display("[TB] FAIL mid.reset got %b want 0_0000_0_1", {out_valid, illegal_cnt, err_sticky, in_ready});
    else passCount++;
  endtask

  task automatic test_drain();
    int budget;
    out_ready = 1'b1; in_valid = 1'b0;
    budget = 10;
    while (out_valid && budget > 0) begin
      tick();
      budget--;
    end
    tick();
    checkCount++;
    if (out_valid !== 1'b0 || expQ.size() != 0) $display("[TB] FAIL drain got valid=%b queue=%0d want 0/0", out_valid, expQ.size());
    else passCount++;
  endtask

  initial begin
    aluCodeOf["add"] = 0;   aluCodeOf["addi"] = 0;  aluCodeOf["lui"] = 0;   aluCodeOf["auipc"] = 0;
    aluCodeOf["load"] = 0;  aluCodeOf["store"] = 0; aluCodeOf["jal"] = 0;   aluCodeOf["sub"] = 1;
    aluCodeOf["and"] = 2;   aluCodeOf["andi"] = 2;  aluCodeOf["or"] = 3;    aluCodeOf["ori"] = 3;
    aluCodeOf["xor"] = 4;   aluCodeOf["xori"] = 4;  aluCodeOf["sll"] = 5;   aluCodeOf["slli"] = 5;
    aluCodeOf["slt"] = 6;   aluCodeOf["slti"] = 6;  aluCodeOf["sltu"] = 7;  aluCodeOf["sltiu"] = 7;
    aluCodeOf["srl"] = 8;   aluCodeOf["srli"] = 8;  aluCodeOf["sra"] = 9;   aluCodeOf["srai"] = 9;
    aluCodeOf["jalr"] = 10; aluCodeOf["beq"] = 11;  aluCodeOf["bne"] = 12;  aluCodeOf["blt"] = 13;
    aluCodeOf["bge"] = 14;  aluCodeOf["bltu"] = 15; aluCodeOf["bgeu"] = 16;
    test_reset();
    test_decode();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_drain();
    test_saturation();
    test_reset_midstall();
    test_drain();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Registered decode-and-issue stage that sits directly upstream of the single-cycle `alu`. It accepts an RV32I instruction word with its register operands and PC over a valid/ready handshake. It translates the instruction into the ALU's 5-bit `aluc` code and its `a`/`b` operand pair, then presents them on a registered valid/ready output. Illegal encodings are flagged and counted.

## Interface
- `CNT_W`, default 16: width of the illegal-instruction counter.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream offers an instruction.
- `in_ready` out 1: stage accepts when `in_valid & in_ready`.
- `instr` in 32: RV32I instruction word.
- `rs1_val` in 32: rs1 register value.
- `rs2_val` in 32: rs2 register value.
- `pc` in 32: instruction address.
- `out_valid` out 1: issue bundle valid.
- `out_ready` in 1: ALU side consumes when `out_valid & out_ready`.
- `aluc` out 5: ALU operation code.
- `a` out 32: ALU operand a.
- `b` out 32: ALU operand b.
- `is_branch` out 1: `aluc` is a compare code (01011–10000); consumer reads `condition_branch`.
- `illegal` out 1: this bundle came from an illegal encoding.
- `err_sticky` out 1: set on the first illegal accept; cleared only by `rst`.
- `illegal_cnt` out CNT_W: count of accepted illegal instructions; saturates at all-ones.

## Operation
Decode depends only on opcode/funct3/funct7. Immediates are sign-extended per I/S/B/U formats.

- **R-type and OP-IMM**: `a=rs1_val`, `b=rs2_val` or imm.
  - ADD/ADDI 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, SLT 00110, SLTU 00111.
- **Shifts**: the ALU shifts `b` by `a[4:0]`, so `a={27'b0,shamt}` and `b=rs1_val`.
  - shamt is `rs2_val[4:0]` for register shifts, `instr[24:20]` for immediate shifts.
  - SLL 00101, SRL 01000, SRA 01001.
  - SLLI/SRLI/SRAI with `instr[25]=1` are illegal.
- **LUI**: 00000, `a=0`, `b={instr[31:12],12'b0}`.
- **AUIPC**: 00000, `a=pc`, `b=U-imm`.
- **LOAD/STORE**: 00000, `a=rs1_val`, `b=I/S-imm`.
- **JAL**: 00000, `a=pc`, `b=4`.
- **JALR**: 01010, `a=rs1_val`, `b=I-imm`. The ALU clears bit 0.
- **BRANCH**: `a=rs1_val`, `b=rs2_val`.
  - BEQ 01011, BNE 01100, BLT 01101, BGE 01110, BLTU 01111, BGEU 10000.
  - funct3 010/011 are illegal.
- **Illegal**: any other opcode, any funct7 other than 0000000/0100000 where applicable, or SUB/SRA funct7 on a funct3 that does not take it.
  - Issue `aluc=0`, `a=0`, `b=0`, `illegal=1`, `is_branch=0`.
  - The bundle is still issued, never dropped.
  - `illegal_cnt` increments and `err_sticky` sets on the accept cycle.
- **Output hold**: the output register holds its contents while `out_valid & ~out_ready`. Outputs never change while stalled.

## Timing
- **Reset**: `out_valid=0`, `aluc=0`, `a=0`, `b=0`, `is_branch=0`, `illegal=0`, `err_sticky=0`, `illegal_cnt=0`.
  - `in_ready=1` in the first cycle after reset deasserts, in both configurations.
- **Latency**: an input accepted at edge N appears on the outputs after edge N. One cycle, registered.
- **Throughput**: one instruction per cycle when `out_ready` is held high.
- **Simultaneous accept and consume**: the register reloads with the new bundle and `out_valid` stays 1.
- **Consume with no new input**: `out_valid` falls to 0 on the next edge.
- **`rst` mid-stall**: the pending bundle is discarded. Counter and sticky flag are cleared.
- **Counter at all-ones**: further illegal accepts leave it unchanged. `err_sticky` stays 1.
- **`in_valid` with `in_ready=0`**: ignored. Inputs are not sampled.

## Configuration
- **`ALU_ISSUE_SKID_EN` defined**:
  - Adds a second (skid) entry.
  - `in_ready` is a flop, asserted whenever the skid entry is empty. There is no combinational path from `out_ready` to `in_ready`.
  - An accept during a stall lands in the skid entry. The skid entry moves to the output register on the next consume, with order preserved.
  - `illegal_cnt` counts at accept, not at issue.
- **Not defined**:
  - Single entry. `in_ready = ~out_valid | out_ready`, combinational.
  - Skid logic is absent.

## Test plan
- **ADD**: `0x003100B3` (add x1,x2,x3), rs1=5, rs2=7, `out_ready=1` → next cycle `aluc=00000`, `a=5`, `b=7`, `out_valid=1`, `is_branch=0`.
- **SRAI**: `0x4041D093` (srai x1,x3,4), rs1=0x80000000 → `aluc=01001`, `a=4`, `b=0x80000000`.
- **BLTU**: `0x0020E463`, rs1=1, rs2=2 → `aluc=01111`, `a=1`, `b=2`, `is_branch=1`.
- **Illegal**: `0xFFFFFFFF` accepted twice → two bundles with `illegal=1`, `aluc=0`; `illegal_cnt=2`, `err_sticky=1`. Then `rst` → all zero.
- **Backpressure**: hold `out_ready=0` for 3 cycles with `in_valid=1`.
  - Without `ALU_ISSUE_SKID_EN`: one bundle held stable; `in_ready=0` until release.
  - With `ALU_ISSUE_SKID_EN`: two accepted; `in_ready=0` in the 2nd stall cycle; both issued in order after release.
- **JALR/LUI**: JALR `0x004080E7` with rs1=0x101 → `aluc=01010`, `a=0x101`, `b=4`. LUI `0x123450B7` → `aluc=00000`, `a=0`, `b=0x12345000`.
